mux_arbiter: RTL and testbench

- Two-requester burst arbiter that shares one SIZE-bit mux datapath between sources A and B.
- Grants ownership round-robin on burst boundaries and drives the mux SEL.
- Registers the selected word into a valid/ready output stage.
- Sits directly upstream of the shared mux and any downstream consumer with backpressure.

---
 rtl/mux_arbiter.sv | 121 ++++++++++++
 tb/tb_mux_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Two-requester round-robin burst arbiter driving a shared mux select,
// with a single-entry valid/ready output register.
module mux_arbiter #(
   parameter int SIZE      = 1,
   parameter int MAX_BURST = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            REQ_A,
   input  logic [SIZE-1:0] DATA_A,
   input  logic            LAST_A,
   output logic            GNT_A,
   input  logic            REQ_B,
   input  logic [SIZE-1:0] DATA_B,
   input  logic            LAST_B,
   output logic            GNT_B,
   output logic            SEL,
   output logic [SIZE-1:0] OUT,
   output logic            OUT_VALID,
   input  logic            OUT_READY
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arbState_t;

   localparam logic [7:0] LP_COUNT_MAX = 8'(MAX_BURST - 1);

   arbState_t       r_state;
   arbState_t       w_stateNext;
   logic            r_prio;
   logic [7:0]      r_count;
   logic [SIZE-1:0] r_out;
   logic            r_outValid;

   logic            w_slotFree;
   logic            w_countMax;
   logic            w_gntA;
   logic            w_gntB;
   logic            w_transfer;
   logic            w_release;
   logic [SIZE-1:0] w_data;

   assign w_slotFree = !r_outValid || OUT_READY;
   assign w_countMax = (r_count == LP_COUNT_MAX);
   assign w_transfer = w_gntA || w_gntB;
   assign w_data     = w_gntB ? DATA_B : DATA_A;

   // Arbitration: grants only flow from an owning state, and a release hands
   // straight over to a waiting peer so there is no bubble between bursts.
   always_comb begin
      w_stateNext = r_state;
      w_gntA      = 1'b0;
      w_gntB      = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         IDLE: begin
            if (REQ_A && REQ_B) begin
               w_stateNext = r_prio ? OWN_B : OWN_A;
            end else if (REQ_A) begin
               w_stateNext = OWN_A;
            end else if (REQ_B) begin
               w_stateNext = OWN_B;
            end
         end
         OWN_A: begin
            w_gntA = REQ_A && w_slotFree;
            if (w_gntA && (LAST_A || w_countMax)) begin
               w_release   = 1'b1;
               w_stateNext = REQ_B ? OWN_B : IDLE;
            end
         end
         OWN_B: begin
            w_gntB = REQ_B && w_slotFree;
            if (w_gntB && (LAST_B || w_countMax)) begin
               w_release   = 1'b1;
               w_stateNext = REQ_A ? OWN_A : IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_prio  <= 1'b0;
         r_count <= 8'd0;
      end else begin
         r_state <= w_stateNext;
         if (w_release) begin
            r_count <= 8'd0;
            r_prio  <= (r_state == OWN_A);
         end else if (w_transfer) begin
            r_count <= r_count + 8'd1;
         end
      end
   end

   // Output word register; a consumed word clears VALID but OUT keeps its value.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_out      <= '0;
         r_outValid <= 1'b0;
      end else if (w_transfer) begin
         r_out      <= w_data;
         r_outValid <= 1'b1;
      end else if (OUT_READY && r_outValid) begin
         r_outValid <= 1'b0;
      end
   end

   assign GNT_A     = w_gntA;
   assign GNT_B     = w_gntB;
   assign SEL       = (r_state == OWN_B);
   assign OUT       = r_out;
   assign OUT_VALID = r_outValid;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter (SIZE=8, MAX_BURST=4): handover, forced
// release, backpressure, mid-burst request drop and mid-burst reset.
module tb_mux_arbiter;

   logic       CLK;
   logic       RST;
   logic       REQ_A;
   logic [7:0] DATA_A;
   logic       LAST_A;
   logic       GNT_A;
   logic       REQ_B;
   logic [7:0] DATA_B;
   logic       LAST_B;
   logic       GNT_B;
   logic       SEL;
   logic [7:0] OUT;
   logic       OUT_VALID;
   logic       OUT_READY;

   int nCompared = 0;
   int nFail     = 0;

   mux_arbiter #(.SIZE(8), .MAX_BURST(4)) dut (
      .CLK(CLK), .RST(RST),
      .REQ_A(REQ_A), .DATA_A(DATA_A), .LAST_A(LAST_A), .GNT_A(GNT_A),
      .REQ_B(REQ_B), .DATA_B(DATA_B), .LAST_B(LAST_B), .GNT_B(GNT_B),
      .SEL(SEL), .OUT(OUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance past the next rising edge; inputs change 1ns after it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic reqA, input logic [7:0] dA, input logic lastA,
                                input logic reqB, input logic [7:0] dB, input logic lastB,
                                input logic ready);
      REQ_A = reqA; DATA_A = dA; LAST_A = lastA;
      REQ_B = reqB; DATA_B = dB; LAST_B = lastB;
      OUT_READY = ready;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic doReset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b0;
      applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);

      // Single A burst of three beats
      doReset();
      checkOutput("rst_valid", {7'd0, OUT_VALID}, 8'h00);
      checkOutput("rst_out", OUT, 8'h00);
      checkOutput("rst_sel", {7'd0, SEL}, 8'h00);
      applyStimulus(1, 8'h11, 0, 0, 8'h00, 0, 1);
      checkOutput("s1_idle_gnta", {7'd0, GNT_A}, 8'h00);
      tick();
      applyStimulus(1, 8'h11, 0, 0, 8'h00, 0, 1);
      checkOutput("s1_c1_gnta", {7'd0, GNT_A}, 8'h01);
      checkOutput("s1_c1_sel", {7'd0, SEL}, 8'h00);
      tick();
      applyStimulus(1, 8'h22, 0, 0, 8'h00, 0, 1);
      checkOutput("s1_c2_out", OUT, 8'h11);
      checkOutput("s1_c2_valid", {7'd0, OUT_VALID}, 8'h01);
      checkOutput("s1_c2_gnta", {7'd0, GNT_A}, 8'h01);
      tick();
      applyStimulus(1, 8'h33, 1, 0, 8'h00, 0, 1);
      checkOutput("s1_c3_out", OUT, 8'h22);
      checkOutput("s1_c3_gnta", {7'd0, GNT_A}, 8'h01);
      tick();
      applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
      checkOutput("s1_c4_out", OUT, 8'h33);
      checkOutput("s1_c4_valid", {7'd0, OUT_VALID}, 8'h01);
      checkOutput("s1_c4_gnta", {7'd0, GNT_A}, 8'h00);
      checkOutput("s1_c4_sel", {7'd0, SEL}, 8'h00);
      tick();
      checkOutput("s1_c5_valid", {7'd0, OUT_VALID}, 8'h00);
      checkOutput("s1_c5_out_hold", OUT, 8'h33);

      // Both request from reset: A then B with no bubble
      doReset();
      applyStimulus(1, 8'hA0, 0, 1, 8'hB0, 0, 1);
      checkOutput("s2_idle_gnta", {7'd0, GNT_A}, 8'h00);
      checkOutput("s2_idle_gntb", {7'd0, GNT_B}, 8'h00);
      tick();
      applyStimulus(1, 8'hA0, 0, 1, 8'hB0, 0, 1);
      checkOutput("s2_c1_gnta", {7'd0, GNT_A}, 8'h01);
      checkOutput("s2_c1_gntb", {7'd0, GNT_B}, 8'h00);
      checkOutput("s2_c1_sel", {7'd0, SEL}, 8'h00);
      tick();
      applyStimulus(1, 8'hA1, 1, 1, 8'hB0, 0, 1);
      checkOutput("s2_c2_out", OUT, 8'hA0);
      checkOutput("s2_c2_gnta", {7'd0, GNT_A}, 8'h01);
      tick();
      applyStimulus(0, 8'h00, 0, 1, 8'hB0, 0, 1);
      checkOutput("s2_c3_sel", {7'd0, SEL}, 8'h01);
      checkOutput("s2_c3_gntb", {7'd0, GNT_B}, 8'h01);
      checkOutput("s2_c3_out", OUT, 8'hA1);
      tick();
      applyStimulus(0, 8'h00, 0, 1, 8'hB1, 1, 1);
      checkOutput("s2_c4_out", OUT, 8'hB0);
      checkOutput("s2_c4_gntb", {7'd0, GNT_B}, 8'h01);
      tick();
      applyStimulus(1, 8'hA2, 0, 1, 8'hB2, 0, 1);
      checkOutput("s2_c5_out", OUT, 8'hB1);
      checkOutput("s2_c5_sel", {7'd0, SEL}, 8'h00);
      tick();
      applyStimulus(1, 8'hA2, 0, 1, 8'hB2, 0, 1);
      checkOutput("s2_prio_a_sel", {7'd0, SEL}, 8'h00);
      checkOutput("s2_prio_a_gnta", {7'd0, GNT_A}, 8'h01);

      // B streams without LAST: forced release after 4 beats
      doReset();
      applyStimulus(0, 8'h00, 0, 1, 8'h01, 0, 1);
      tick();
      applyStimulus(0, 8'h00, 0, 1, 8'h01, 0, 1);
      checkOutput("s3_c1_gntb", {7'd0, GNT_B}, 8'h01);
      checkOutput("s3_c1_sel", {7'd0, SEL}, 8'h01);
      tick();
      applyStimulus(0, 8'h00, 0, 1, 8'h02, 0, 1);
      tick();
      applyStimulus(0, 8'h00, 0, 1, 8'h03, 0, 1);
      tick();
      applyStimulus(0, 8'h00, 0, 1, 8'h04, 0, 1);
      checkOutput("s3_c4_gntb", {7'd0, GNT_B}, 8'h01);
      checkOutput("s3_c4_out", OUT, 8'h03);
      tick();
      applyStimulus(0, 8'h00, 0, 1, 8'h05, 0, 1);
      checkOutput("s3_c5_sel_idle", {7'd0, SEL}, 8'h00);
      checkOutput("s3_c5_gntb", {7'd0, GNT_B}, 8'h00);
      checkOutput("s3_c5_out", OUT, 8'h04);
      tick();
      applyStimulus(0, 8'h00, 0, 1, 8'h05, 0, 1);
      checkOutput("s3_c6_sel", {7'd0, SEL}, 8'h01);
      checkOutput("s3_c6_gntb", {7'd0, GNT_B}, 8'h01);
      checkOutput("s3_c6_valid", {7'd0, OUT_VALID}, 8'h00);
      tick();
      applyStimulus(0, 8'h00, 0, 1, 8'h06, 0, 1);
      checkOutput("s3_c7_out", OUT, 8'h05);
      tick();
      applyStimulus(0, 8'h00, 0, 1, 8'h07, 0, 1);
      checkOutput("s3_c8_out", OUT, 8'h06);
      checkOutput("s3_c8_gntb", {7'd0, GNT_B}, 8'h01);
      tick();
      applyStimulus(0, 8'h00, 0, 1, 8'h08, 0, 1);
      checkOutput("s3_c9_gntb", {7'd0, GNT_B}, 8'h01);
      tick();
      applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
      checkOutput("s3_c10_sel_rel", {7'd0, SEL}, 8'h00);
      checkOutput("s3_c10_out", OUT, 8'h08);

      // Backpressure on A stream
      doReset();
      applyStimulus(1, 8'h51, 0, 0, 8'h00, 0, 1);
      tick();
      applyStimulus(1, 8'h51, 0, 0, 8'h00, 0, 1);
      checkOutput("s4_c1_gnta", {7'd0, GNT_A}, 8'h01);
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 8'h52, 0, 0, 8'h00, 0, 0);
         checkOutput("s4_stall_gnta", {7'd0, GNT_A}, 8'h00);
         checkOutput("s4_stall_out", OUT, 8'h51);
         checkOutput("s4_stall_valid", {7'd0, OUT_VALID}, 8'h01);
         tick();
      end
      applyStimulus(1, 8'h52, 0, 0, 8'h00, 0, 1);
      checkOutput("s4_resume_gnta", {7'd0, GNT_A}, 8'h01);
      checkOutput("s4_resume_out", OUT, 8'h51);
      tick();
      applyStimulus(1, 8'h53, 1, 0, 8'h00, 0, 1);
      checkOutput("s4_c6_out", OUT, 8'h52);
      checkOutput("s4_c6_gnta", {7'd0, GNT_A}, 8'h01);
      tick();
      applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
      checkOutput("s4_c7_out", OUT, 8'h53);
      checkOutput("s4_c7_valid", {7'd0, OUT_VALID}, 8'h01);

      // B drops REQ mid-burst: ownership held, A locked out
      doReset();
      applyStimulus(0, 8'h00, 0, 1, 8'hC1, 0, 1);
      tick();
      applyStimulus(0, 8'h00, 0, 1, 8'hC1, 0, 1);
      tick();
      applyStimulus(0, 8'h00, 0, 1, 8'hC2, 0, 1);
      tick();
      applyStimulus(1, 8'hEE, 0, 0, 8'h00, 0, 1);
      checkOutput("s5_drop_sel", {7'd0, SEL}, 8'h01);
      checkOutput("s5_drop_gnta", {7'd0, GNT_A}, 8'h00);
      checkOutput("s5_drop_gntb", {7'd0, GNT_B}, 8'h00);
      checkOutput("s5_drop_out", OUT, 8'hC2);
      tick();
      applyStimulus(1, 8'hEE, 0, 0, 8'h00, 0, 1);
      checkOutput("s5_drop2_sel", {7'd0, SEL}, 8'h01);
      checkOutput("s5_drop2_gnta", {7'd0, GNT_A}, 8'h00);
      checkOutput("s5_drop2_valid", {7'd0, OUT_VALID}, 8'h00);
      tick();
      applyStimulus(1, 8'hEE, 0, 1, 8'hC3, 0, 1);
      checkOutput("s5_ret_gntb", {7'd0, GNT_B}, 8'h01);
      checkOutput("s5_ret_gnta", {7'd0, GNT_A}, 8'h00);
      tick();
      applyStimulus(1, 8'hEE, 0, 1, 8'hC4, 0, 1);
      checkOutput("s5_c6_out", OUT, 8'hC3);
      checkOutput("s5_c6_gntb", {7'd0, GNT_B}, 8'h01);
      tick();
      applyStimulus(1, 8'hEE, 0, 0, 8'h00, 0, 1);
      checkOutput("s5_hand_sel", {7'd0, SEL}, 8'h00);
      checkOutput("s5_hand_out", OUT, 8'hC4);
      checkOutput("s5_hand_gnta", {7'd0, GNT_A}, 8'h01);
      tick();

      // Reset while A owns with a valid word in the output stage
      checkOutput("s6_pre_out", OUT, 8'hEE);
      checkOutput("s6_pre_valid", {7'd0, OUT_VALID}, 8'h01);
      RST = 1'b1;
      applyStimulus(1, 8'hEE, 0, 1, 8'hDD, 0, 1);
      tick();
      RST = 1'b0;
      applyStimulus(1, 8'h77, 0, 1, 8'hDD, 0, 1);
      checkOutput("s6_rst_valid", {7'd0, OUT_VALID}, 8'h00);
      checkOutput("s6_rst_out", OUT, 8'h00);
      checkOutput("s6_rst_sel", {7'd0, SEL}, 8'h00);
      checkOutput("s6_rst_gnta", {7'd0, GNT_A}, 8'h00);
      checkOutput("s6_rst_gntb", {7'd0, GNT_B}, 8'h00);
      tick();
      applyStimulus(1, 8'h77, 0, 1, 8'hDD, 0, 1);
      checkOutput("s6_cold_sel", {7'd0, SEL}, 8'h00);
      checkOutput("s6_cold_gnta", {7'd0, GNT_A}, 8'h01);
      tick();
      applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
      checkOutput("s6_cold_out", OUT, 8'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
      $finish;
   end

endmodule
